dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arb_starve_ctr.sv | 31 +++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM two-master arbiter.
// No logic; imported by the interface, the arbiter top and the starvation counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_CW  = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both master ports and the DMEM port; slave = arbiter side, master = environment side.
// Requests are held until granted; grants are same-cycle, read data returns one cycle later.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Master 1 starvation counter; module exists only when DMEM_ARB_STARVE_EN is defined.
// Flag is registered-count based: asserts once m1 has lost STARVE_MAX consecutive cycles.
`ifdef DMEM_ARB_STARVE_EN
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic starve_flag
);

  logic [STARVE_CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (m1_req && !m1_gnt) begin
      if (cnt != {STARVE_CW{1'b1}}) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign starve_flag = (cnt >= STARVE_CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Two-master DMEM arbiter, m0 fixed priority; DMEM_ARB_STARVE_EN adds forced m1 grant after STARVE_MAX losses.
// Grant is combinational (0 cycles), read data registered (1 cycle); losers hold req until granted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be within 1..15");
  end

  owner_e            owner;
  logic              starve_flag;
  logic              m0_gnt;
  logic              m1_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              we_sel;

  logic              m0_rvalid_q;
  logic              m1_rvalid_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk         (clk),
    .reset       (reset),
    .m1_req      (bus.m1_req),
    .m1_gnt      (m1_gnt),
    .starve_flag (starve_flag)
  );
`else
  assign starve_flag = 1'b0;
`endif

  // Nothing is granted while reset is asserted, even with requests present.
  always_comb begin
    owner = OWN_NONE;
    if (!reset) begin
      if (bus.m0_req && bus.m1_req) owner = starve_flag ? OWN_M1 : OWN_M0;
      else if (bus.m0_req)          owner = OWN_M0;
      else if (bus.m1_req)          owner = OWN_M1;
    end
  end

  assign m0_gnt = (owner == OWN_M0);
  assign m1_gnt = (owner == OWN_M1);

  // Idle cycles park the DMEM address/data on m0's values.
  always_comb begin
    addr_sel  = bus.m0_addr;
    wdata_sel = bus.m0_wdata;
    we_sel    = 1'b0;
    unique case (owner)
      OWN_M0: we_sel = bus.m0_we;
      OWN_M1: begin
        addr_sel  = bus.m1_addr;
        wdata_sel = bus.m1_wdata;
        we_sel    = bus.m1_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_gnt && !bus.m0_we;
      m1_rvalid_q <= m1_gnt && !bus.m1_we;
      if (m0_gnt && !bus.m0_we) m0_rdata_q <= bus.mem_rdata;
      if (m1_gnt && !bus.m1_we) m1_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.m0_gnt    = m0_gnt;
  assign bus.m1_gnt    = m1_gnt;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_we    = we_sel;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-level model of the arbitration rules,
// a shadow copy of memory and a consecutive-loss count for master 1.
module tb_dmem_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic env_clr;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // DMEM stand-in: combinational read, write at the edge.
  logic [31:0] env_mem [64];
  assign bus.mem_rdata = env_mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= 32'h0;
    end else if (bus.mem_we) begin
      env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          lost  = 0;
  int          m1_seen = 0;
  logic [31:0] shadow [64];
  logic        erv0, erv1;
  logic [31:0] erd0, erd1;
  logic        g0, g1;

  logic        p0, pwe0, p1, pwe1;
  logic [31:0] pa0, pd0, pa1, pd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic cycle(input logic rst,
                       input logic r0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       output logic w0, output logic w1);
    reset        = rst;
    bus.m0_req   = r0;  bus.m0_we = we0;  bus.m0_addr = a0;  bus.m0_wdata = d0;
    bus.m1_req   = r1;  bus.m1_we = we1;  bus.m1_addr = a1;  bus.m1_wdata = d1;
    #2;
    w1 = !rst && r1 && (!r0 || (STARVE_ON && lost >= STARVE_MAX));
    w0 = !rst && r0 && !w1;
    check("m0_gnt",    64'(bus.m0_gnt),    64'(w0));
    check("m1_gnt",    64'(bus.m1_gnt),    64'(w1));
    check("mem_we",    64'(bus.mem_we),    64'((w0 && we0) || (w1 && we1)));
    check("mem_addr",  64'(bus.mem_addr),  64'(w1 ? a1 : a0));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(w1 ? d1 : d0));
    if (bus.m1_gnt) m1_seen++;
    @(posedge clk);
    #1;
    if (rst) begin
      lost = 0;
      erv0 = 1'b0;  erv1 = 1'b0;
      erd0 = 32'h0; erd1 = 32'h0;
    end else begin
      lost = (r1 && !w1) ? lost + 1 : 0;
      erv0 = w0 && !we0;
      erv1 = w1 && !we1;
      if (erv0) erd0 = shadow[a0[7:2]];
      if (erv1) erd1 = shadow[a1[7:2]];
      if (w0 && we0) shadow[a0[7:2]] = d0;
      if (w1 && we1) shadow[a1[7:2]] = d1;
    end
    check("m0_rvalid", 64'(bus.m0_rvalid), 64'(erv0));
    check("m1_rvalid", 64'(bus.m1_rvalid), 64'(erv1));
    check("m0_rdata",  64'(bus.m0_rdata),  64'(erd0));
    check("m1_rdata",  64'(bus.m1_rdata),  64'(erd1));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
  endtask

  initial begin
    foreach (shadow[i]) shadow[i] = 32'h0;
    env_clr = 1'b1;
    reset   = 1'b1;
    erv0 = 1'b0; erv1 = 1'b0; erd0 = 32'h0; erd1 = 32'h0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset held with both masters requesting writes: nothing may be granted.
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 32'h10, 32'hAAAA_0000, 1'b1, 1'b1, 32'h20, 32'hBBBB_0000, g0, g1);
    env_clr = 1'b0;
    check("rst_m0_rdata", 64'(bus.m0_rdata), 64'h0);
    check("rst_m1_rvalid", 64'(bus.m1_rvalid), 64'h0);

    // m0 loads 0xDEADBEEF at 0x10, then reads it back alone.
    cycle(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
    cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
    check("t_m0_read_rvalid", 64'(bus.m0_rvalid), 64'h1);
    check("t_m0_read_rdata",  64'(bus.m0_rdata),  64'hDEAD_BEEF);
    idle();
    check("t_m0_rdata_hold",  64'(bus.m0_rdata),  64'hDEAD_BEEF);

    // m1 write then read of 0x20.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, g0, g1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
    check("t_m1_read_rvalid", 64'(bus.m1_rvalid), 64'h1);
    check("t_m1_read_rdata",  64'(bus.m1_rdata),  64'h1234_5678);

    // Both requesting continuously for 100 cycles.
    idle();
    m1_seen = 0;
    for (int c = 0; c < 100; c++)
      cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
    check("contention_m1_grants", 64'(m1_seen), STARVE_ON ? 64'(100 / (STARVE_MAX + 1)) : 64'h0);

    // Build up m1 losses, grant an m0 read, then reset: read return and loss count must clear.
    idle();
    repeat (2) cycle(1'b0, 1'b1, 1'b1, 32'h30, 32'h5555_AAAA, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
    cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
    cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
    check("rst_mid_m0_rvalid", 64'(bus.m0_rvalid), 64'h0);
    check("rst_mid_m0_rdata",  64'(bus.m0_rdata),  64'h0);
    m1_seen = 0;
    for (int c = 0; c < STARVE_MAX + 1; c++)
      cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, g0, g1);
    check("post_rst_m1_grants", 64'(m1_seen), STARVE_ON ? 64'h1 : 64'h0);

    // Random traffic with held requests and occasional resets.
    p0 = 1'b0; p1 = 1'b0;
    pwe0 = 1'b0; pwe1 = 1'b0; pa0 = 32'h0; pa1 = 32'h0; pd0 = 32'h0; pd1 = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; pwe0 = 1'($urandom_range(0, 1));
        pa0 = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pwe1 = 1'($urandom_range(0, 1));
        pa1 = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; pd1 = $urandom;
      end
      cycle(1'($urandom_range(0, 49) == 0), p0, pwe0, pa0, pd0, p1, pwe1, pa1, pd1, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
